// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, single-outstanding imem handshake,
// IF/ID pipeline register with a one-entry skid for responses that arrive during a decode stall.
//
// state | meaning
// REQ   | request pending on imem (held off in the first cycle out of reset)
// WAIT  | request granted, waiting for imem_rvalid
// HOLD  | response parked in the skid until decode releases its stall
module fetch_unit #(
    parameter int                 ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [31:0]        NOP_WORD = 32'hD503201F
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_stall,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                drop_q, drop_d;
    logic                boot_q;
    logic [31:0]         skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
    logic                valid_q, valid_d;
    logic [31:0]         instr_q, instr_d;
    logic [ADDR_W-1:0]   ifpc_q, ifpc_d;

    logic                req;
    logic                take;
    logic                slot_free;
    logic                load;
    logic [31:0]         load_instr;
    logic [ADDR_W-1:0]   load_pc;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   target;

    // boot_q keeps imem_req low for the first cycle after reset release
    assign req       = (state_q == S_REQ) && !boot_q;
    assign take      = req && imem_gnt;
    assign slot_free = !valid_q || !id_stall;
    assign pc_inc    = pc_q + ADDR_W'(4);
    assign target    = redirect_pc & ALIGN_MASK;

    assign imem_req    = req;
    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ifpc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= PC_INIT;
            drop_q       <= 1'b0;
            boot_q       <= 1'b1;
            skid_instr_q <= NOP_WORD;
            skid_pc_q    <= '0;
            valid_q      <= 1'b0;
            instr_q      <= NOP_WORD;
            ifpc_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            boot_q       <= 1'b0;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            ifpc_q       <= ifpc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        ifpc_d       = ifpc_q;
        load         = 1'b0;
        load_instr   = imem_rdata;
        load_pc      = pc_q;

        if (redirect) begin
            // Flush wins over everything; an in-flight response is marked for discard
            valid_d      = 1'b0;
            instr_d      = NOP_WORD;
            skid_instr_d = NOP_WORD;
            skid_pc_d    = '0;
            pc_d         = target;
            unique case (state_q)
                S_REQ: begin
                    if (take) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                S_HOLD: state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (take) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (slot_free) begin
                            load    = 1'b1;
                            pc_d    = pc_inc;
                            state_d = S_REQ;
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = pc_q;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!id_stall) begin
                        load       = 1'b1;
                        load_instr = skid_instr_q;
                        load_pc    = skid_pc_q;
                        pc_d       = pc_inc;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase

            if (load) begin
                valid_d = 1'b1;
                instr_d = load_instr;
                ifpc_d  = load_pc;
            end else if (!id_stall) begin
                valid_d = 1'b0;
                instr_d = NOP_WORD;
            end
        end
    end

endmodule
